// File: rtl/pipelined_carry_inc_adder_if.sv
// rtl/pipelined_carry_inc_adder_if.sv - operand/result handshake bundle for the carry-increment adder
interface pipelined_carry_inc_adder_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c0;
   logic             sub;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output a, b, c0, sub, in_valid, out_ready,
      input  in_ready, sum, cout, ovf, out_valid
   );

   modport slave (
      input  a, b, c0, sub, in_valid, out_ready,
      output in_ready, sum, cout, ovf, out_valid
   );
endinterface

// File: rtl/pipelined_carry_inc_adder.sv
// rtl/pipelined_carry_inc_adder.sv - carry-increment adder/subtractor, one pipeline stage per BLK-bit block
module pipelined_carry_inc_adder #(
   parameter int WIDTH = 32,
   parameter int BLK   = 8
) (
   input logic                        clk,
   input logic                        rst_n,
   pipelined_carry_inc_adder_if.slave bus
);
   localparam int STAGES = WIDTH / BLK;

   if (BLK < 2 || WIDTH < BLK || (WIDTH % BLK) != 0) begin : g_bad_cfg
      $error("pipelined_carry_inc_adder: WIDTH must be a positive multiple of BLK and BLK >= 2");
   end

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

   // Whole pipeline moves in lockstep; only a held result at the output can stall it.
   assign adv          = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = adv;

   // Subtraction folds into addition here, so later stages never see the mode bit.
   assign b_eff   = bus.sub ? ~bus.b : bus.b;
   assign cin_eff = bus.sub | bus.c0;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int IW = WIDTH - k * BLK;
      localparam int OW = (k + 1) * BLK;

      logic [IW-1:0]  a_i;
      logic [IW-1:0]  b_i;
      logic           c_i;
      logic           v_i;
      logic [BLK-1:0] rs;
      logic           rc;
      logic [BLK:0]   hc;
      logic [BLK-1:0] s;
      logic           c_d;
      logic [OW-1:0]  sum_d;

      logic           v_q;
      logic           c_q;
      logic [OW-1:0]  sum_q;

      if (k == 0) begin : g_first
         assign a_i   = bus.a;
         assign b_i   = b_eff;
         assign c_i   = cin_eff;
         assign v_i   = bus.in_valid;
         assign sum_d = s;
      end else begin : g_next
         assign a_i   = g_stg[k-1].g_fwd.a_q;
         assign b_i   = g_stg[k-1].g_fwd.b_q;
         assign c_i   = g_stg[k-1].c_q;
         assign v_i   = g_stg[k-1].v_q;
         assign sum_d = {s, g_stg[k-1].sum_q};
      end

      assign {rc, rs} = {1'b0, a_i[BLK-1:0]} + {1'b0, b_i[BLK-1:0]};

      // Incoming carry is applied afterwards as an increment through a half-adder chain.
      assign hc[0] = c_i;
      for (genvar j = 0; j < BLK; j++) begin : g_ha
         assign s[j]    = rs[j] ^ hc[j];
         assign hc[j+1] = rs[j] & hc[j];
      end

      assign c_d = rc | hc[BLK];

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            v_q   <= 1'b0;
            c_q   <= 1'b0;
            sum_q <= '0;
         end else if (adv) begin
            v_q <= v_i;
            if (v_i) begin
               c_q   <= c_d;
               sum_q <= sum_d;
            end
         end
      end

      if (IW > BLK) begin : g_fwd
         logic [IW-BLK-1:0] a_q;
         logic [IW-BLK-1:0] b_q;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv && v_i) begin
               a_q <= a_i[IW-1:BLK];
               b_q <= b_i[IW-1:BLK];
            end
         end
      end

      // The final block holds the operand MSBs, so signed overflow is resolved here.
      if (k == STAGES - 1) begin : g_last
         logic ovf_q;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (adv && v_i) begin
               ovf_q <= (a_i[BLK-1] == b_i[BLK-1]) && (s[BLK-1] != a_i[BLK-1]);
            end
         end
      end
   end

   assign bus.out_valid = g_stg[STAGES-1].v_q;
   assign bus.sum       = g_stg[STAGES-1].sum_q;
   assign bus.cout      = g_stg[STAGES-1].c_q;
   assign bus.ovf       = g_stg[STAGES-1].g_last.ovf_q;
endmodule

// File: tb/tb_pipelined_carry_inc_adder.sv
// tb/tb_pipelined_carry_inc_adder.sv - directed and randomized checks of the carry-increment adder
module tb_pipelined_carry_inc_adder;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   pipelined_carry_inc_adder_if #(.WIDTH(32)) i32 ();
   pipelined_carry_inc_adder_if #(.WIDTH(16)) i16 ();
   pipelined_carry_inc_adder_if #(.WIDTH(64)) i64 ();

   pipelined_carry_inc_adder #(.WIDTH(32), .BLK(8))  u32 (.clk(clk), .rst_n(rst_n), .bus(i32.slave));
   pipelined_carry_inc_adder #(.WIDTH(16), .BLK(4))  u16 (.clk(clk), .rst_n(rst_n), .bus(i16.slave));
   pipelined_carry_inc_adder #(.WIDTH(64), .BLK(16)) u64 (.clk(clk), .rst_n(rst_n), .bus(i64.slave));

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: plain integer addition for the carry, signed range test for overflow.
   function automatic res_t ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                    input logic c0, input logic sub);
      logic [63:0]        mask;
      logic [63:0]        bp;
      logic               cin;
      logic [65:0]        tot;
      logic signed [67:0] sa, sb, ss, lim;
      res_t               r;
      mask  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      a     = a & mask;
      bp    = sub ? (~b & mask) : (b & mask);
      cin   = sub ? 1'b1 : c0;
      tot   = {2'b00, a} + {2'b00, bp} + {65'd0, cin};
      r.sum = tot[63:0] & mask;
      r.cout = tot[w];
      sa = $signed({4'b0000, a});
      if (a[w-1]) sa = sa - (68'sd1 <<< w);
      sb = $signed({4'b0000, bp});
      if (bp[w-1]) sb = sb - (68'sd1 <<< w);
      ss  = sa + sb + $signed({67'd0, cin});
      lim = 68'sd1 <<< (w - 1);
      r.ovf = (ss >= lim) || (ss < -lim);
      return r;
   endfunction

   function automatic logic [71:0] pk(input res_t r);
      return {6'b0, r.ovf, r.cout, r.sum};
   endfunction

   function automatic logic [71:0] obs32();
      return {6'b0, i32.ovf, i32.cout, 32'h0, i32.sum};
   endfunction

   function automatic logic [71:0] obs16();
      return {6'b0, i16.ovf, i16.cout, 48'h0, i16.sum};
   endfunction

   function automatic logic [71:0] obs64();
      return {6'b0, i64.ovf, i64.cout, i64.sum};
   endfunction

   function automatic logic [63:0] rnd_op();
      case ($urandom_range(0, 7))
         0:       return 64'hFFFF_FFFF_FFFF_FFFF;
         1:       return 64'h0;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic c0, input logic sub, output res_t got);
      int   edges;
      res_t exp;
      @(negedge clk);
      i32.a = a; i32.b = b; i32.c0 = c0; i32.sub = sub;
      i32.in_valid = 1'b1; i32.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i32.in_valid = 1'b0;
      edges = 1;
      while (!i32.out_valid && edges < 20) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      chk({tag, "_latency"}, edges, 4);
      exp = ref_add(32, {32'h0, a}, {32'h0, b}, c0, sub);
      chk({tag, "_result"}, obs32(), pk(exp));
      got.sum = {32'h0, i32.sum}; got.cout = i32.cout; got.ovf = i32.ovf;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_drained"}, i32.out_valid, 0);
      chk({tag, "_hold"}, obs32(), pk(exp));
   endtask

   initial begin
      res_t        r;
      res_t        q32[$];
      res_t        q16[$];
      res_t        q64[$];
      int          got, sent, stall_left, extra, first_out, last_out, s16, s64;
      bit          stalled;
      logic        acc, drn, acc16, drn16, acc64, drn64;
      logic [63:0] ra, rb, ra2, rb2;
      logic        rc0, rsub, rc02, rsub2;

      i32.a = '0; i32.b = '0; i32.c0 = 0; i32.sub = 0; i32.in_valid = 0; i32.out_ready = 1;
      i16.a = '0; i16.b = '0; i16.c0 = 0; i16.sub = 0; i16.in_valid = 0; i16.out_ready = 1;
      i64.a = '0; i64.b = '0; i64.c0 = 0; i64.sub = 0; i64.in_valid = 0; i64.out_ready = 1;
      rst_n = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", i32.out_valid, 0);
      chk("rst_outputs", obs32(), 72'h0);
      chk("rst_out_valid16", i16.out_valid, 0);
      chk("rst_out_valid64", i64.out_valid, 0);
      rst_n = 1'b1;
      #1;
      chk("rst_release_ready", i32.in_ready, 1);

      single("add_wrap", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, r);
      chk("add_wrap_const", pk(r), {6'b0, 1'b0, 1'b1, 64'h0});
      single("sub", 32'h5, 32'h7, 1'b1, 1'b1, r);
      chk("sub_const", pk(r), {6'b0, 1'b0, 1'b0, 64'hFFFF_FFFE});
      single("ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, r);
      chk("ovf_const", pk(r), {6'b0, 1'b1, 1'b0, 64'h8000_0000});

      // back-to-back mixed add/sub stream at full rate
      got = 0; first_out = -1; last_out = -1;
      for (int cyc = 0; cyc < 24; cyc++) begin
         @(negedge clk);
         if (i32.out_valid) begin
            chk("stream_pending", q32.size() > 0, 1);
            if (q32.size() > 0) chk("stream_result", obs32(), pk(q32.pop_front()));
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            got++;
         end
         i32.out_ready = 1'b1;
         i32.in_valid = (cyc < 8);
         ra = rnd_op(); rb = rnd_op();
         i32.a = ra[31:0]; i32.b = rb[31:0];
         i32.c0 = ($urandom_range(0, 1) == 1); i32.sub = ($urandom_range(0, 1) == 1);
         #1;
         if (i32.in_valid && i32.in_ready)
            q32.push_back(ref_add(32, ra, rb, i32.c0, i32.sub));
      end
      chk("stream_count", got, 8);
      chk("stream_gapless", last_out - first_out + 1, 8);

      // backpressure: 3-cycle stall once the first result shows up
      sent = 0; got = 0; stall_left = 0; stalled = 0;
      for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
         @(negedge clk);
         if (i32.out_valid && !stalled) begin
            stalled = 1; stall_left = 3;
         end
         i32.out_ready = (stall_left == 0);
         i32.in_valid = (sent < 6);
         i32.a = 32'(sent + 1); i32.b = 32'(sent + 1); i32.c0 = 1'b0; i32.sub = 1'b0;
         #1;
         if (stall_left > 0) begin
            chk("bp_in_ready", i32.in_ready, 0);
            chk("bp_hold_valid", i32.out_valid, 1);
            chk("bp_hold_sum", i32.sum, 2);
            stall_left--;
         end
         acc = i32.in_valid && i32.in_ready;
         drn = i32.out_valid && i32.out_ready;
         if (drn) begin
            chk("bp_seq", i32.sum, 2 * (got + 1));
            got++;
         end
         @(posedge clk);
         if (acc) sent++;
      end
      chk("bp_count", got, 6);
      @(negedge clk);
      i32.in_valid = 1'b0; i32.out_ready = 1'b1;
      extra = 0;
      repeat (8) begin
         @(posedge clk);
         @(negedge clk);
         if (i32.out_valid) extra++;
      end
      chk("bp_no_dup", extra, 0);

      // reset with three beats in flight, in_valid held high through the reset edge
      i32.in_valid = 1'b1; i32.out_ready = 1'b1;
      i32.a = 32'h1234_5678; i32.b = 32'h1111_1111;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_out_valid", i32.out_valid, 0);
      chk("midrst_outputs", obs32(), 72'h0);
      rst_n = 1'b1;
      i32.in_valid = 1'b0;
      #1;
      chk("midrst_in_ready", i32.in_ready, 1);
      extra = 0;
      repeat (8) begin
         @(posedge clk);
         @(negedge clk);
         if (i32.out_valid) extra++;
      end
      chk("midrst_no_stale", extra, 0);

      // random sweep on the 16/4 and 64/16 configurations
      s16 = 0; s64 = 0;
      for (int cyc = 0; cyc < 40000 && (s16 < 10000 || s64 < 10000 ||
                                         q16.size() > 0 || q64.size() > 0); cyc++) begin
         @(negedge clk);
         ra = rnd_op(); rb = rnd_op();
         rc0 = ($urandom_range(0, 1) == 1); rsub = ($urandom_range(0, 1) == 1);
         ra2 = rnd_op(); rb2 = rnd_op();
         rc02 = ($urandom_range(0, 1) == 1); rsub2 = ($urandom_range(0, 1) == 1);
         i16.a = ra[15:0]; i16.b = rb[15:0]; i16.c0 = rc0; i16.sub = rsub;
         i16.in_valid  = (s16 < 10000) && ($urandom_range(0, 3) != 0);
         i16.out_ready = ($urandom_range(0, 3) != 0);
         i64.a = ra2; i64.b = rb2; i64.c0 = rc02; i64.sub = rsub2;
         i64.in_valid  = (s64 < 10000) && ($urandom_range(0, 3) != 0);
         i64.out_ready = ($urandom_range(0, 3) != 0);
         #1;
         acc16 = i16.in_valid && i16.in_ready;
         drn16 = i16.out_valid && i16.out_ready;
         acc64 = i64.in_valid && i64.in_ready;
         drn64 = i64.out_valid && i64.out_ready;
         if (drn16) begin
            chk("sw16_pending", q16.size() > 0, 1);
            if (q16.size() > 0) chk("sw16_result", obs16(), pk(q16[0]));
         end
         if (drn64) begin
            chk("sw64_pending", q64.size() > 0, 1);
            if (q64.size() > 0) chk("sw64_result", obs64(), pk(q64[0]));
         end
         @(posedge clk);
         if (drn16 && q16.size() > 0) q16.pop_front();
         if (drn64 && q64.size() > 0) q64.pop_front();
         if (acc16) begin
            q16.push_back(ref_add(16, ra, rb, rc0, rsub));
            s16++;
         end
         if (acc64) begin
            q64.push_back(ref_add(64, ra2, rb2, rc02, rsub2));
            s64++;
         end
      end
      chk("sw16_sent", s16, 10000);
      chk("sw64_sent", s64, 10000);
      chk("sw16_drained", q16.size(), 0);
      chk("sw64_drained", q64.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
